// File: rtl/pipelined_control_unit.sv
// RV32I (optional RV32M) decode plus the ID/EX, EX/MEM and MEM/WB control pipeline,
// with load-use stall detection and EX-stage branch/jump resolution.
module pipelined_control_unit #(
  parameter int unsigned ALU_CTRL_W = 5,
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          MUL_EN     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [2:0]            id_funct3,
  input  logic [6:0]            id_funct7,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_zero,
  input  logic                  ex_lt,
  input  logic                  ex_ltu,
  output logic [2:0]            id_imm_src,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic                  ex_alu_src_a,
  output logic                  ex_alu_src_b,
  output logic [1:0]            pc_select,
  output logic                  flush,
  output logic                  stall,
  output logic                  ex_illegal,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  output logic [2:0]            mem_funct3,
  output logic                  wb_reg_write_enable,
  output logic [1:0]            wb_result_src,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ALU    = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_PASS_B = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd16;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  src_a;
    logic                  src_b;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic [2:0]            funct3;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
    logic                  illegal;
    logic                  valid;
  } ctrl_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  ctrl_t     dec;
  ctrl_t     id_ex_d, id_ex_q;
  mem_ctrl_t ex_mem_d, ex_mem_q;
  wb_ctrl_t  mem_wb_d, mem_wb_q;
  logic [4:0] alu_sel;
  logic       bad;
  logic       use_rs1;
  logic       use_rs2;
  logic       br_taken;
  logic       load_use;

  // funct3 -> ALU code for the shared OP/OP_IMM arithmetic group
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    logic [4:0] r;
    case (f3)
      3'd0:    r = ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Instruction decode into a control word
  always_comb begin
    dec        = '0;
    alu_sel    = ALU_ADD;
    bad        = 1'b0;
    use_rs1    = 1'b1;
    use_rs2    = 1'b0;
    id_imm_src = IMM_I;
    case (id_opcode)
      OPC_LOAD: begin
        dec.src_b      = 1'b1;
        dec.mem_read   = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_MEM;
      end
      OPC_STORE: begin
        dec.src_b     = 1'b1;
        dec.mem_write = 1'b1;
        use_rs2       = 1'b1;
        id_imm_src    = IMM_S;
      end
      OPC_BRANCH: begin
        alu_sel    = ALU_SUB;
        dec.branch = 1'b1;
        use_rs2    = 1'b1;
        id_imm_src = IMM_B;
      end
      OPC_JAL: begin
        dec.src_a      = 1'b1;
        dec.src_b      = 1'b1;
        dec.jal        = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        use_rs1        = 1'b0;
        id_imm_src     = IMM_J;
      end
      OPC_JALR: begin
        dec.src_b      = 1'b1;
        dec.jalr       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
      end
      OPC_IMM: begin
        dec.src_b     = 1'b1;
        dec.reg_write = 1'b1;
        alu_sel       = base_alu(id_funct3);
        // funct7 is immediate bits except for the shift encodings
        if (id_funct3 == 3'd1 && id_funct7 != F7_BASE) begin
          bad = 1'b1;
        end else if (id_funct3 == 3'd5) begin
          if (id_funct7 == F7_ALT)       alu_sel = ALU_SRA;
          else if (id_funct7 != F7_BASE) bad = 1'b1;
        end
      end
      OPC_ALU: begin
        dec.reg_write = 1'b1;
        use_rs2       = 1'b1;
        if (id_funct7 == F7_BASE)                          alu_sel = base_alu(id_funct3);
        else if (id_funct7 == F7_ALT && id_funct3 == 3'd0) alu_sel = ALU_SUB;
        else if (id_funct7 == F7_ALT && id_funct3 == 3'd5) alu_sel = ALU_SRA;
        else if (MUL_EN && id_funct7 == F7_MUL)            alu_sel = ALU_MUL + {2'b00, id_funct3};
        else                                               bad = 1'b1;
      end
      OPC_LUI: begin
        alu_sel       = ALU_PASS_B;
        dec.src_b     = 1'b1;
        dec.reg_write = 1'b1;
        use_rs1       = 1'b0;
        id_imm_src    = IMM_U;
      end
      OPC_AUIPC: begin
        dec.src_a     = 1'b1;
        dec.src_b     = 1'b1;
        dec.reg_write = 1'b1;
        use_rs1       = 1'b0;
        id_imm_src    = IMM_U;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: bad = 1'b1;
    endcase
    dec.alu_control = ALU_CTRL_W'(alu_sel);
    dec.funct3      = id_funct3;
    dec.rd          = id_rd;
    dec.valid       = 1'b1;
    if (id_rd == '0) dec.reg_write = 1'b0;
    // An illegal word keeps only its identity fields; every enable drops
    if (bad) begin
      dec         = '0;
      dec.funct3  = id_funct3;
      dec.rd      = id_rd;
      dec.illegal = 1'b1;
      dec.valid   = 1'b1;
    end
    if (!id_valid) dec = '0;
  end

  // Branch resolution and hazard controls, combinational from ID inputs and ID/EX
  always_comb begin
    br_taken = 1'b0;
    case (id_ex_q.funct3)
      3'b000:  br_taken = ex_zero;
      3'b001:  br_taken = !ex_zero;
      3'b100:  br_taken = ex_lt;
      3'b101:  br_taken = !ex_lt;
      3'b110:  br_taken = ex_ltu;
      3'b111:  br_taken = !ex_ltu;
      default: br_taken = 1'b0;
    endcase
    flush     = id_ex_q.valid && ((id_ex_q.branch && br_taken) || id_ex_q.jal || id_ex_q.jalr);
    pc_select = 2'd0;
    if (flush) pc_select = id_ex_q.jalr ? 2'd2 : 2'd1;
    load_use  = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                ((use_rs1 && id_ex_q.rd == id_rs1) || (use_rs2 && id_ex_q.rd == id_rs2));
    stall     = id_valid && load_use && !flush;
  end

  always_comb begin
    id_ex_d             = (stall || flush) ? '0 : dec;
    ex_mem_d.mem_read   = id_ex_q.mem_read;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.funct3     = id_ex_q.funct3;
    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.result_src = id_ex_q.result_src;
    ex_mem_d.rd         = id_ex_q.rd;
    mem_wb_d.reg_write  = ex_mem_q.reg_write;
    mem_wb_d.result_src = ex_mem_q.result_src;
    mem_wb_d.rd         = ex_mem_q.rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign ex_alu_control      = id_ex_q.alu_control;
  assign ex_alu_src_a        = id_ex_q.src_a;
  assign ex_alu_src_b        = id_ex_q.src_b;
  assign ex_illegal          = id_ex_q.illegal;
  assign mem_write_enable    = ex_mem_q.mem_write;
  assign mem_read_enable     = ex_mem_q.mem_read;
  assign mem_funct3          = ex_mem_q.funct3;
  assign wb_reg_write_enable = mem_wb_q.reg_write;
  assign wb_result_src       = mem_wb_q.result_src;
  assign wb_rd               = mem_wb_q.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: two DUTs (MUL_EN=1 and MUL_EN=0) share stimulus; a per-instruction
// reference model predicts each cycle's outputs, a negedge monitor compares.
module tb_pipelined_control_unit;

  localparam logic [6:0] LOAD = 7'b0000011, FENCE = 7'b0001111, OPIMM = 7'b0010011;
  localparam logic [6:0] AUIPC = 7'b0010111, STORE = 7'b0100011, OP = 7'b0110011;
  localparam logic [6:0] LUI = 7'b0110111, BRANCH = 7'b1100011, JALR = 7'b1100111;
  localparam logic [6:0] JAL = 7'b1101111, SYSTEM = 7'b1110011;
  localparam int ALU_OF_F3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  typedef struct packed {
    logic v, ill, br, jal, jalr, mr, mw, rw, sa, sb;
    logic [4:0] alu;
    logic [2:0] f3;
    logic [1:0] rs;
    logic [4:0] rd;
  } m_t;

  typedef struct packed {
    logic [2:0] imm;
    logic [4:0] alu;
    logic sa, sb;
    logic [1:0] pcs;
    logic fl, st, ill, mwe, mre;
    logic [2:0] mf3;
    logic wwe;
    logic [1:0] wrs;
    logic [4:0] wrd;
  } o_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0;
  logic [6:0] id_opcode = '0, id_funct7 = '0;
  logic [2:0] id_funct3 = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic ex_zero = 1'b0, ex_lt = 1'b0, ex_ltu = 1'b0;

  logic [2:0] imm1, imm0, mf31, mf30;
  logic [4:0] alu1, alu0, wrd1, wrd0;
  logic [1:0] pcs1, pcs0, wrs1, wrs0;
  logic sa1, sb1, fl1, st1, ill1, mwe1, mre1, wwe1;
  logic sa0, sb0, fl0, st0, ill0, mwe0, mre0, wwe0;

  pipelined_control_unit #(.ALU_CTRL_W(5), .REG_ADDR_W(5), .MUL_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .id_imm_src(imm1), .ex_alu_control(alu1), .ex_alu_src_a(sa1), .ex_alu_src_b(sb1),
    .pc_select(pcs1), .flush(fl1), .stall(st1), .ex_illegal(ill1),
    .mem_write_enable(mwe1), .mem_read_enable(mre1), .mem_funct3(mf31),
    .wb_reg_write_enable(wwe1), .wb_result_src(wrs1), .wb_rd(wrd1));

  pipelined_control_unit #(.ALU_CTRL_W(5), .REG_ADDR_W(5), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .id_imm_src(imm0), .ex_alu_control(alu0), .ex_alu_src_a(sa0), .ex_alu_src_b(sb0),
    .pc_select(pcs0), .flush(fl0), .stall(st0), .ex_illegal(ill0),
    .mem_write_enable(mwe0), .mem_read_enable(mre0), .mem_funct3(mf30),
    .wb_reg_write_enable(wwe0), .wb_result_src(wrs0), .wb_rd(wrd0));

  o_t act1, act0;
  assign act1 = {imm1, alu1, sa1, sb1, pcs1, fl1, st1, ill1, mwe1, mre1, mf31, wwe1, wrs1, wrd1};
  assign act0 = {imm0, alu0, sa0, sb0, pcs0, fl0, st0, ill0, mwe0, mre0, mf30, wwe0, wrs0, wrd0};

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  o_t q1[$];
  o_t q0[$];
  m_t mex[2], mmem[2], mwb[2];
  bit last_stall = 1'b0;

  // What the instruction means, straight from the ISA tables
  function automatic m_t ref_decode(input bit mul, input logic v, input logic [6:0] op,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [4:0] rd);
    m_t m;
    bit ill;
    int alu;
    m = '0; ill = 1'b0; alu = 0;
    if (!v) return m;
    case (op)
      LOAD:   begin m.mr = 1; m.rw = 1; m.sb = 1; m.rs = 2'd1; end
      STORE:  begin m.mw = 1; m.sb = 1; end
      BRANCH: begin m.br = 1; alu = 1; end
      JAL:    begin m.jal = 1; m.rw = 1; m.sa = 1; m.sb = 1; m.rs = 2'd2; end
      JALR:   begin m.jalr = 1; m.rw = 1; m.sb = 1; m.rs = 2'd2; end
      LUI:    begin m.rw = 1; m.sb = 1; alu = 10; end
      AUIPC:  begin m.rw = 1; m.sa = 1; m.sb = 1; end
      OPIMM: begin
        m.rw = 1; m.sb = 1; alu = ALU_OF_F3[f3];
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) alu = 7;
          else if (f7 != 7'h00) ill = 1'b1;
        end
      end
      OP: begin
        m.rw = 1;
        if (f7 == 7'h00) alu = ALU_OF_F3[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 7;
        else if (f7 == 7'h01 && mul) alu = 16 + int'(f3);
        else ill = 1'b1;
      end
      FENCE, SYSTEM: ;
      default: ill = 1'b1;
    endcase
    m.v = 1'b1; m.f3 = f3; m.rd = rd; m.alu = 5'(alu);
    if (ill) begin
      m = '0; m.v = 1'b1; m.ill = 1'b1; m.f3 = f3; m.rd = rd;
    end
    return m;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      STORE:      return 3'd1;
      BRANCH:     return 3'd2;
      JAL:        return 3'd3;
      LUI, AUIPC: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  // One cycle: drive inputs after the edge, predict outputs, advance the model
  task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic z, input logic lt, input logic ltu,
                      input logic rst);
    @(posedge clk); #1;
    id_valid = v; id_opcode = op; id_funct3 = f3; id_funct7 = f7;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_zero = z; ex_lt = lt; ex_ltu = ltu; reset = rst;
    for (int k = 0; k < 2; k++) begin
      m_t x;
      bit tk, fl, st, u1, u2;
      o_t e;
      x = mex[k];
      case (x.f3)
        3'd0: tk = z;    3'd1: tk = !z;
        3'd4: tk = lt;   3'd5: tk = !lt;
        3'd6: tk = ltu;  3'd7: tk = !ltu;
        default: tk = 1'b0;
      endcase
      fl = x.v && ((x.br && tk) || x.jal || x.jalr);
      u1 = !(op == LUI || op == AUIPC || op == JAL);
      u2 = (op == BRANCH || op == STORE || op == OP);
      st = !fl && v && x.v && x.mr && x.rd != 5'd0 &&
           ((u1 && x.rd == r1) || (u2 && x.rd == r2));
      e.imm = imm_of(op);
      e.alu = x.alu; e.sa = x.sa; e.sb = x.sb;
      e.pcs = !fl ? 2'd0 : (x.jalr ? 2'd2 : 2'd1);
      e.fl = fl; e.st = st; e.ill = x.ill;
      e.mwe = mmem[k].mw; e.mre = mmem[k].mr; e.mf3 = mmem[k].f3;
      e.wwe = mwb[k].rw && mwb[k].rd != 5'd0;
      e.wrs = mwb[k].rs; e.wrd = mwb[k].rd;
      if (k == 1) begin q1.push_back(e); last_stall = st; end
      else q0.push_back(e);
      if (rst) begin
        mex[k] = '0; mmem[k] = '0; mwb[k] = '0;
      end else begin
        mwb[k]  = mmem[k];
        mmem[k] = mex[k];
        mex[k]  = (fl || st) ? '0 : ref_decode(k == 1, v, op, f3, f7, rd);
      end
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    o_t e;
    cyc++;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      tests++;
      if (act1 !== e) begin
        fails++;
        $display("FAIL mul_en1 cyc=%0d got=%h want=%h", cyc, act1, e);
      end
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      tests++;
      if (act0 !== e) begin
        fails++;
        $display("FAIL mul_en0 cyc=%0d got=%h want=%h", cyc, act0, e);
      end
    end
  end

  initial begin
    logic v, z, lt, ltu, rst;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] r1, r2, rd;
    logic [6:0] ops [11];
    ops = '{LOAD, STORE, BRANCH, JAL, JALR, OPIMM, OP, LUI, AUIPC, FENCE, SYSTEM};
    for (int k = 0; k < 2; k++) begin mex[k] = '0; mmem[k] = '0; mwb[k] = '0; end

    // ADD, SUB, LUI then drain to writeback
    step(1, OP,  3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
    step(1, OP,  3'd0, 7'h20, 5'd1, 5'd2, 5'd7, 0, 0, 0, 0);
    step(1, LUI, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 0, 0, 0, 0);
    nop(3);
    // load-use: stalled ADD re-presented, then rd=x0 case
    step(1, LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd4, 0, 0, 0, 0);
    step(1, OP,   3'd0, 7'h00, 5'd4, 5'd2, 5'd6, 0, 0, 0, 0);
    step(1, OP,   3'd0, 7'h00, 5'd4, 5'd2, 5'd6, 0, 0, 0, 0);
    step(1, LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd0, 0, 0, 0, 0);
    step(1, OP,   3'd0, 7'h00, 5'd0, 5'd2, 5'd6, 0, 0, 0, 0);
    nop(3);
    // BEQ taken, back-to-back BEQ, BNE not taken
    step(1, BRANCH, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0);
    step(1, BRANCH, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0);
    step(1, OP,     3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);
    step(1, BRANCH, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0);
    step(1, OP,     3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);
    // JALR x1,0(x2)
    step(1, JALR, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 0, 0, 0, 0);
    nop(4);
    // MUL encoding on both DUTs
    step(1, OP, 3'd0, 7'h01, 5'd1, 5'd2, 5'd8, 0, 0, 0, 0);
    nop(4);
    // load then hazarding branch, taken branch meeting a load-use pair, reset mid-stream
    step(1, LOAD,   3'd2, 7'h00, 5'd1, 5'd0, 5'd4, 0, 0, 0, 0);
    step(1, BRANCH, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 0, 0, 0, 0);
    step(1, BRANCH, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 0, 0, 0, 0);
    step(1, LOAD,   3'd2, 7'h00, 5'd1, 5'd0, 5'd4, 1, 0, 0, 0);
    step(1, OP,     3'd0, 7'h00, 5'd4, 5'd2, 5'd6, 1, 0, 0, 1);
    step(1, OP,     3'd0, 7'h00, 5'd4, 5'd2, 5'd6, 0, 0, 0, 0);
    nop(3);

    // randomized traffic; a stalled instruction is re-presented unchanged
    op = OP; f3 = '0; f7 = '0; r1 = '0; r2 = '0; rd = '0; v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        int sel;
        sel = int'($urandom_range(0, 11));
        op  = (sel == 11) ? 7'($urandom) : ops[sel];
        f3  = 3'($urandom);
        case ($urandom_range(0, 3))
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          2: f7 = 7'h01;
          default: f7 = 7'($urandom);
        endcase
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        v  = ($urandom_range(0, 9) != 0);
      end
      z   = 1'($urandom);
      lt  = 1'($urandom);
      ltu = 1'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step(v, op, f3, f7, r1, r2, rd, z, lt, ltu, rst);
    end
    nop(2);

    repeat (3) @(negedge clk);
    #1;
    if (q1.size() != 0 || q0.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain left=%0d want=0", q1.size() + q0.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Parametrised decode-and-control block for the 5-stage RV32I pipeline. It decodes the IF/ID instruction fields and carries the control word through ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and emits stall. It resolves branches and jumps in EX and emits flush and pc_select. An optional mode adds RV32M decode.

## Interface
- ALU_CTRL_W, 5, width of the ALU control code; must be ≥5 when MUL_EN=1.
- REG_ADDR_W, 5, register index width.
- MUL_EN, 0, when 1, OP_ALU with funct7=0000001 decodes as M-extension ops; when 0 such encodings are illegal.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode / id_funct3 / id_funct7  in  7/3/7  instruction fields.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  register indices.
- ex_zero, ex_lt, ex_ltu  in  1 each  ALU comparison flags for the EX instruction.
- id_imm_src  out  3  combinational; I=0, S=1, B=2, J=3, U=4.
- ex_alu_control  out  ALU_CTRL_W  registered.
- ex_alu_src_a, ex_alu_src_b  out  1 each  registered; a=1 selects PC (AUIPC/JAL), b=1 selects immediate.
- pc_select  out  2  combinational from EX; 0=PC+4, 1=PC+imm, 2=rs1+imm.
- flush, stall  out  1 each  combinational hazard controls.
- ex_illegal  out  1  registered; EX holds an undecodable instruction.
- mem_write_enable, mem_read_enable  out  1 each; mem_funct3  out  3.
- wb_reg_write_enable  out  1; wb_result_src  out  2 (0=ALU, 1=memory, 2=PC+4); wb_rd  out  REG_ADDR_W.

## Operation
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10 (LUI). With MUL_EN, codes are 16+funct3 (MUL…REMU).
- Loads, stores, JALR, AUIPC and JAL use ADD. BRANCH uses SUB.
- OP_IMM SRAI/SRLI is selected by funct7[5]. OP_ALU uses funct7[5] for SUB/SRA.
- FENCE and ECALL decode as NOP: no writes, not illegal. Any other unknown opcode, or a bad funct7, sets the illegal bit. An illegal control word has all enables forced to 0.
- Control word fields: alu_control, src_a/src_b, branch, jal, jalr, funct3, mem_read, mem_write, reg_write, result_src, rd, illegal, valid.
- Branch taken in EX, per funct3: BEQ = ex_zero; BNE = !ex_zero; BLT = ex_lt; BGE = !ex_lt; BLTU = ex_ltu; BGEU = !ex_ltu.
- flush is asserted when the EX word is valid and is either a taken branch or a JAL/JALR. It drives pc_select to 1 or 2; otherwise pc_select is 0.
- Register use: rs1 is used by every opcode except LUI/AUIPC/JAL. rs2 is used by BRANCH/STORE/OP_ALU.
- Load-use stall: stall=1 when all of the following hold:
  - id_valid is high;
  - the ID/EX word is valid with mem_read set;
  - its rd≠0;
  - its rd equals a used id_rs1 or id_rs2.
- Priority: flush overrides stall. When flush is high, stall is forced to 0.
- On stall or flush, ID/EX loads a bubble (all zero). EX/MEM and MEM/WB always advance.
- A writeback with rd=0 has wb_reg_write_enable forced to 0.

## Timing
- Decode to ex_* outputs: 1 cycle. mem_* outputs: 2 cycles. wb_* outputs: 3 cycles.
- id_imm_src, stall, flush and pc_select are combinational in the same cycle. There is no registered path from id_* inputs to them.
- Reset: all pipeline registers clear to bubble. Every registered output is 0, and pc_select=0, flush=0, stall=0 in the cycle after reset is sampled.
- Reset asserted mid-operation overrides stall and flush on the same edge.
- A stalled instruction re-presented on the next cycle must decode identically.
- Back-to-back taken branches: the second is a bubble and produces no second flush.

## Test plan
- ADD x3,x1,x2 (opcode 0110011, f3=0, f7=0) then SUB, LUI x5 → ex_alu_control = 0, 1, 10 on successive cycles. wb_reg_write_enable=1 and wb_rd=3 appear 3 cycles after the ADD.
- LW x4,0(x1) followed by ADD x6,x4,x2 → stall=1 for exactly 1 cycle and ID/EX receives a bubble. With rd=x0 instead, there is no stall.
- BEQ with ex_zero=1 → flush=1, pc_select=1, next ex_* is a bubble. BNE with ex_zero=1 → flush=0, pc_select=0.
- JALR x1,0(x2) → pc_select=2, flush=1; 2 cycles later wb_result_src=2.
- MUL encoding (f7=0000001, f3=0): MUL_EN=1 → ex_alu_control=16, ex_illegal=0. MUL_EN=0 → ex_illegal=1 with all enables 0.
- Load-use stall coinciding with a taken branch in EX, then reset asserted mid-stream → flush=1, stall=0. The cycle after reset, all outputs are 0.
